// File: rtl/ex_pkg.sv
// ex_pkg: shared class codes, funct3 encodings and MUL/DIV FSM states for the execute stage
package ex_pkg;
  localparam logic [4:0] T_NOP    = 5'd0;
  localparam logic [4:0] T_RALU   = 5'd1;
  localparam logic [4:0] T_IALU   = 5'd2;
  localparam logic [4:0] T_LOAD   = 5'd3;
  localparam logic [4:0] T_STORE  = 5'd4;
  localparam logic [4:0] T_BRANCH = 5'd5;
  localparam logic [4:0] T_JAL    = 5'd6;
  localparam logic [4:0] T_JALR   = 5'd7;
  localparam logic [4:0] T_LUI    = 5'd8;
  localparam logic [4:0] T_AUIPC  = 5'd9;
  localparam logic [4:0] T_MULDIV = 5'd10;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;
  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;
  localparam int MD_ITER = 32;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/ex_if.sv
// ex_if: ID/EX inputs and EX/MEM plus control outputs of the execute stage
interface ex_if #(parameter int XLEN = 32);
  logic            Valid_In;
  logic [31:0]     Inst_In;
  logic [XLEN-1:0] PC_In;
  logic [XLEN-1:0] Operand_A_val_In;
  logic [XLEN-1:0] Operand_B_val_In;
  logic [XLEN-1:0] Immx_Data_In;
  logic [4:0]      Inst_Type_In;
  logic            branch_kill_flag;
  logic [XLEN-1:0] Branch_Target_Out;
  logic            Stall_Out;
  logic            Valid_Out;
  logic [XLEN-1:0] Alu_Result_Out;
  logic [XLEN-1:0] Store_Data_Out;
  logic [4:0]      Rd_Out;
  logic [4:0]      Inst_Type_Out;
  modport master (
    output Valid_In, Inst_In, PC_In, Operand_A_val_In, Operand_B_val_In, Immx_Data_In, Inst_Type_In,
    input  branch_kill_flag, Branch_Target_Out, Stall_Out, Valid_Out, Alu_Result_Out, Store_Data_Out, Rd_Out, Inst_Type_Out
  );
  modport slave (
    input  Valid_In, Inst_In, PC_In, Operand_A_val_In, Operand_B_val_In, Immx_Data_In, Inst_Type_In,
    output branch_kill_flag, Branch_Target_Out, Stall_Out, Valid_Out, Alu_Result_Out, Store_Data_Out, Rd_Out, Inst_Type_Out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// muldiv_unit: iterative 32-step shift-add multiplier / restoring divider on operand magnitudes
module muldiv_unit import ex_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  md_state_e   state;
  logic [4:0]  cnt;
  logic [2:0]  f3;
  logic        a_neg, b_neg, b_zero, sa, sb;
  logic [31:0] hi, lo, m, quo, rem;
  logic [32:0] sum, shl, diff;
  logic [63:0] prod;
  assign sa = funct3 inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
  assign sb = funct3 inside {F3_MULH, F3_DIV, F3_REM};
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 33'd0);
  assign shl = {hi, lo[31]};
  assign diff = shl - {1'b0, m};
  assign prod = (a_neg ^ b_neg) ? -{hi, lo} : {hi, lo};
  // divide-by-zero leaves the dividend in hi naturally; only the quotient needs forcing
  assign quo = b_zero ? '1 : (a_neg ^ b_neg) ? -lo : lo;
  assign rem = a_neg ? -hi : hi;
  assign result = f3[2] ? (f3[1] ? rem : quo) : (f3 == F3_MUL ? prod[31:0] : prod[63:32]);
  assign busy = state == MD_BUSY;
  assign done = state == MD_DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt <= '0;
      f3 <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
      b_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
      m <= '0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          state <= MD_BUSY;
          cnt <= '0;
          f3 <= funct3;
          a_neg <= sa & a[31];
          b_neg <= sb & b[31];
          b_zero <= b == '0;
          hi <= '0;
          lo <= (sa & a[31]) ? -a : a;
          m <= (sb & b[31]) ? -b : b;
        end
        MD_BUSY: begin
          cnt <= cnt + 5'd1;
          state <= cnt == 5'(MD_ITER - 1) ? MD_DONE : MD_BUSY;
          hi <= f3[2] ? (diff[32] ? shl[31:0] : diff[31:0]) : sum[32:1];
          lo <= f3[2] ? {lo[30:0], ~diff[32]} : {sum[0], lo[31:1]};
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: RV32IM execute stage with branch resolution, kill, MUL/DIV stall and EX/MEM register
module ex_stage import ex_pkg::*; #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst,
  ex_if.slave bus
);
  logic [4:0]      ty, rd;
  logic [2:0]      f3;
  logic [XLEN-1:0] a, op_b, imm, pc, alu, res, pc_imm, a_imm, target, md_result;
  logic            lt, ltu, eq, br, taken, is_md, stall, md_busy, md_done, unused_bits;
  assign ty = bus.Inst_Type_In;
  assign f3 = bus.Inst_In[14:12];
  assign a = bus.Operand_A_val_In;
  assign imm = bus.Immx_Data_In;
  assign pc = bus.PC_In;
  assign op_b = ty == T_IALU ? imm : bus.Operand_B_val_In;
  assign lt = $signed(a) < $signed(op_b);
  assign ltu = a < op_b;
  assign eq = a == op_b;
  assign unused_bits = ^{bus.Inst_In[31], bus.Inst_In[29:15], bus.Inst_In[6:0]};
  // inst[30] selects SUB only for register ops; for ADDI it is an immediate bit
  assign alu = f3 == F3_ADD  ? (bus.Inst_In[30] & ty == T_RALU ? a - op_b : a + op_b) :
               f3 == F3_SLL  ? a << op_b[4:0] :
               f3 == F3_SLT  ? {{(XLEN-1){1'b0}}, lt} :
               f3 == F3_SLTU ? {{(XLEN-1){1'b0}}, ltu} :
               f3 == F3_XOR  ? a ^ op_b :
               f3 == F3_SR   ? (bus.Inst_In[30] ? $unsigned($signed(a) >>> op_b[4:0]) : a >> op_b[4:0]) :
               f3 == F3_OR   ? a | op_b : a & op_b;
  assign br = f3 == BR_BEQ  ? eq :
              f3 == BR_BNE  ? ~eq :
              f3 == BR_BLT  ? lt :
              f3 == BR_BGE  ? ~lt :
              f3 == BR_BLTU ? ltu :
              f3 == BR_BGEU ? ~ltu : 1'b0;
  assign pc_imm = pc + imm;
  assign a_imm = a + imm;
  assign taken = (ty == T_BRANCH & br) | ty == T_JAL | ty == T_JALR;
  assign is_md = bus.Valid_In & ty == T_MULDIV;
  assign stall = is_md & ~md_done;
  assign target = ty == T_JALR ? {a_imm[XLEN-1:1], 1'b0} : pc_imm;
  assign res = ty inside {T_RALU, T_IALU}   ? alu :
               ty inside {T_LOAD, T_STORE}  ? a_imm :
               ty == T_LUI                  ? imm :
               ty == T_AUIPC                ? pc_imm :
               ty inside {T_JAL, T_JALR}    ? pc + 32'd4 :
               ty == T_MULDIV               ? md_result : '0;
  assign rd = ty == T_BRANCH ? 5'd0 : bus.Inst_In[11:7];
  assign bus.Stall_Out = stall;
  assign bus.branch_kill_flag = bus.Valid_In & taken & ~stall;
  assign bus.Branch_Target_Out = target;
  muldiv_unit u_md (
    .clk(clk),
    .rst(rst),
    .start(is_md & ~md_busy & ~md_done),
    .funct3(f3),
    .a(a),
    .b(bus.Operand_B_val_In),
    .busy(md_busy),
    .done(md_done),
    .result(md_result)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Valid_Out <= 1'b0;
      bus.Alu_Result_Out <= '0;
      bus.Store_Data_Out <= '0;
      bus.Rd_Out <= '0;
      bus.Inst_Type_Out <= '0;
    end else begin
      bus.Valid_Out <= bus.Valid_In & ~stall;
      bus.Alu_Result_Out <= res;
      bus.Store_Data_Out <= bus.Operand_B_val_In;
      bus.Rd_Out <= rd;
      bus.Inst_Type_Out <= ty;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed scoreboard bench for ex_stage
module tb_ex_stage;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [4:0]  ty;
    logic        chk_sd;
    logic [31:0] sd;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t e;
  ex_if bus ();
  ex_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 10'd0, f3, rd, 7'h33};
  endfunction
  task automatic issue(input logic [4:0] ty, input logic [31:0] inst, pc, a, b, imm, res,
                       input logic kill, input logic [31:0] tgt, input int stalls);
    int n = 0;
    bus.Valid_In = 1'b1;
    bus.Inst_Type_In = ty;
    bus.Inst_In = inst;
    bus.PC_In = pc;
    bus.Operand_A_val_In = a;
    bus.Operand_B_val_In = b;
    bus.Immx_Data_In = imm;
    sb.push_back('{res, ty == 5'd5 ? 5'd0 : inst[11:7], ty, ty == 5'd4, b});
    @(negedge clk);
    while (bus.Stall_Out && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("stall_cycles", 32'(n), 32'(stalls));
    chk("kill", 32'(bus.branch_kill_flag), 32'(kill));
    if (kill) chk("target", bus.Branch_Target_Out, tgt);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (bus.Valid_Out === 1'b1) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(bus.Valid_Out), 32'd0);
      else begin
        e = sb.pop_front();
        chk("result", bus.Alu_Result_Out, e.res);
        chk("rd", 32'(bus.Rd_Out), 32'(e.rd));
        chk("type", 32'(bus.Inst_Type_Out), 32'(e.ty));
        if (e.chk_sd) chk("store_data", bus.Store_Data_Out, e.sd);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end
  initial begin
    bus.Valid_In = 1'b0;
    bus.Inst_Type_In = '0;
    bus.Inst_In = '0;
    bus.PC_In = '0;
    bus.Operand_A_val_In = '0;
    bus.Operand_B_val_In = '0;
    bus.Immx_Data_In = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(bus.Valid_Out), 32'd0);
    chk("rst_result", bus.Alu_Result_Out, 32'd0);
    chk("rst_rd", 32'(bus.Rd_Out), 32'd0);
    chk("rst_type", 32'(bus.Inst_Type_Out), 32'd0);
    chk("rst_stall", 32'(bus.Stall_Out), 32'd0);
    rst = 1'b0;
    issue(5'd1, mk(7'h00, 3'd0, 5'd5), 0, 32'h7FFFFFFF, 32'd1, 0, 32'h80000000, 0, 0, 0);
    issue(5'd1, mk(7'h20, 3'd0, 5'd6), 0, 32'd5, 32'd7, 0, 32'hFFFFFFFE, 0, 0, 0);
    issue(5'd1, mk(7'h20, 3'd5, 5'd7), 0, 32'h80000000, 32'd4, 0, 32'hF8000000, 0, 0, 0);
    issue(5'd1, mk(7'h00, 3'd2, 5'd8), 0, 32'd1, 32'hFFFFFFFF, 0, 32'd0, 0, 0, 0);
    issue(5'd1, mk(7'h00, 3'd3, 5'd9), 0, 32'd1, 32'hFFFFFFFF, 0, 32'd1, 0, 0, 0);
    issue(5'd2, mk(7'h00, 3'd4, 5'd10), 0, 32'h0000F0F0, 0, 32'hFFFFFFFF, 32'hFFFF0F0F, 0, 0, 0);
    issue(5'd2, mk(7'h00, 3'd5, 5'd11), 0, 32'h80, 0, 32'd3, 32'h10, 0, 0, 0);
    issue(5'd8, mk(7'h00, 3'd0, 5'd12), 0, 0, 0, 32'h12345000, 32'h12345000, 0, 0, 0);
    issue(5'd9, mk(7'h00, 3'd0, 5'd13), 32'h200, 0, 0, 32'h1000, 32'h1200, 0, 0, 0);
    issue(5'd3, mk(7'h00, 3'd2, 5'd14), 0, 32'hFFFFFFFC, 0, 32'd8, 32'd4, 0, 0, 0);
    issue(5'd4, mk(7'h00, 3'd2, 5'd0), 0, 32'h100, 32'hDEADBEEF, 32'hFFFFFFFC, 32'hFC, 0, 0, 0);
    issue(5'd5, mk(7'h00, 3'd0, 5'd3), 32'h100, 32'd5, 32'd5, 32'h20, 0, 1, 32'h120, 0);
    issue(5'd5, mk(7'h00, 3'd1, 5'd0), 32'h100, 32'd5, 32'd5, 32'h20, 0, 0, 0, 0);
    issue(5'd5, mk(7'h00, 3'd6, 5'd0), 32'h300, 32'd1, 32'd2, 32'hFFFFFFF0, 0, 1, 32'h2F0, 0);
    issue(5'd6, mk(7'h00, 3'd0, 5'd1), 32'h80, 0, 0, 32'h10, 32'h84, 1, 32'h90, 0);
    issue(5'd7, mk(7'h00, 3'd0, 5'd1), 32'h40, 32'h1003, 0, 32'd2, 32'h44, 1, 32'h1004, 0);
    issue(5'd10, mk(7'h01, 3'd4, 5'd13), 0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd5, 5'd14), 0, 32'h12345678, 32'd0, 0, 32'hFFFFFFFF, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd6, 5'd15), 0, 32'd7, 32'd0, 0, 32'd7, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd6, 5'd20), 0, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd4, 5'd21), 0, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFD, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd1, 5'd16), 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd0, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd3, 5'd17), 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd2, 5'd22), 0, 32'hFFFFFFFF, 32'd2, 0, 32'hFFFFFFFF, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd0, 5'd18), 0, 32'd7, 32'd6, 0, 32'd42, 0, 0, 33);
    issue(5'd10, mk(7'h01, 3'd0, 5'd19), 0, 32'hFFFFFFFD, 32'd5, 0, 32'hFFFFFFF1, 0, 0, 33);
    bus.Valid_In = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // launch a divide that is abandoned by reset partway through its iterations
    bus.Valid_In = 1'b1;
    bus.Inst_Type_In = 5'd10;
    bus.Inst_In = mk(7'h01, 3'd4, 5'd23);
    bus.Operand_A_val_In = 32'd100;
    bus.Operand_B_val_In = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.Valid_In = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_valid", 32'(bus.Valid_Out), 32'd0);
    chk("abort_result", bus.Alu_Result_Out, 32'd0);
    chk("abort_rd", 32'(bus.Rd_Out), 32'd0);
    chk("abort_type", 32'(bus.Inst_Type_Out), 32'd0);
    chk("abort_stall", 32'(bus.Stall_Out), 32'd0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    issue(5'd10, mk(7'h01, 3'd0, 5'd24), 0, 32'd3, 32'd4, 0, 32'd12, 0, 0, 33);
    bus.Valid_In = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
